stopwatch_ctrl: RTL

Run/pause/lap controller that sequences a four-digit chain of 0-to-9 decade counters (least significant digit first) from a prescaled tick. It decodes single-cycle start/stop/lap/clear commands into an FSM. It generates the per-digit enable and carry chain, and drives a live count, a lap-freezable display value and a sticky overflow flag. It sits between the push-button/command logic and the seven-segment display driver.

---
 rtl/stopwatch_if.sv | 23 ++
 rtl/stopwatch_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/stopwatch_if.sv
// Command and display bundle between the push-button logic and the stopwatch
// controller; master drives commands, slave returns the count and status.
interface stopwatch_if;
  logic        start;
  logic        stop;
  logic        lap;
  logic        clear;
  logic [15:0] bcd;
  logic [15:0] disp;
  logic [3:0]  dig_en;
  logic        running;
  logic        ovf;

  modport master (
    output start, stop, lap, clear,
    input  bcd, disp, dig_en, running, ovf
  );

  modport slave (
    input  start, stop, lap, clear,
    output bcd, disp, dig_en, running, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap stopwatch: prescaled tick drives a four-digit BCD decade chain,
// with a lap snapshot for the display and a sticky wrap flag.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_presc;
  logic [15:0] r_bcd;
  logic [15:0] r_snap;
  logic        r_ovf;
  logic        w_cnt_en;
  logic        w_tick;
  logic        w_capture;
  logic [3:0]  w_dig_en;

  assign w_cnt_en = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick   = w_cnt_en && (r_presc == 16'(TICK_DIV - 1));

  // Command decode; clear outranks stop, stop outranks lap, lap outranks start.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    if (bus.clear) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (bus.start) w_next_state = S_RUN;
        S_RUN: begin
          if (bus.stop) begin
            w_next_state = S_PAUSE;
          end else if (bus.lap) begin
            w_next_state = S_LAP;
            w_capture    = 1'b1;
          end
        end
        S_LAP: begin
          if (bus.stop)     w_next_state = S_PAUSE;
          else if (bus.lap) w_next_state = S_RUN;
        end
        S_PAUSE: if (bus.start) w_next_state = S_RUN;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    logic carry;
    carry = w_tick;
    for (int k = 0; k < 4; k++) begin
      w_dig_en[k] = carry;
      carry       = carry && (r_bcd[4*k +: 4] == 4'd9);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_bcd   <= '0;
      r_snap  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (bus.clear) begin
        r_presc <= '0;
        r_bcd   <= '0;
        r_snap  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_cnt_en) r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
        for (int k = 0; k < 4; k++) begin
          if (w_dig_en[k])
            r_bcd[4*k +: 4] <= (r_bcd[4*k +: 4] == 4'd9) ? 4'd0 : r_bcd[4*k +: 4] + 4'd1;
        end
        if (w_dig_en[3] && (r_bcd[15:12] == 4'd9)) r_ovf <= 1'b1;
        if (w_capture) r_snap <= r_bcd;
      end
    end
  end

  assign bus.bcd     = r_bcd;
  assign bus.disp    = (r_state == S_LAP) ? r_snap : r_bcd;
  assign bus.dig_en  = w_dig_en;
  assign bus.running = w_cnt_en;
  assign bus.ovf     = r_ovf;

endmodule
